alu_share_arbiter: RTL
======================

Name: alu_share_arbiter

Overview:
- Shares one combinational 32-bit integer ALU between NUM_REQ requesters, for example the integer pipe, the address-generation helper and the debug/CSR path.
- Each requester uses a valid/ready request port. Grants are round-robin.
- The block drives the ALU with the winner's opcode and operands, and captures the result into a single-entry response register tagged with the requester ID.
- Full throughput is one operation per cycle. Latency is one cycle.

Parameters:
- NUM_REQ, 3, number of requesters; legal range 2..8.
- ID_W, 2, requester-ID width; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_req_valid  input  NUM_REQ  per-requester request valid.
- o_req_ready  output  NUM_REQ  per-requester accept; combinational.
- i_req_op  input  4*NUM_REQ  packed 4-bit ALU opcodes {funct7[5],funct3}; requester k uses bits [4k+3:4k].
- i_req_a  input  32*NUM_REQ  packed operand A; requester k uses bits [32k+31:32k].
- i_req_b  input  32*NUM_REQ  packed operand B, same packing as operand A.
- o_alu_op  output  4  opcode to the shared ALU.
- o_alu_a  output  32  operand A to the ALU.
- o_alu_b  output  32  operand B to the ALU.
- i_alu_result  input  32  combinational ALU result.
- o_rsp_valid  output  1  response register holds a result.
- o_rsp_id  output  ID_W  index of the requester that owns the response.
- o_rsp_result  output  32  registered ALU result.
- i_rsp_ready  input  1  consumer accepts the response.

Behaviour:
- Reset (i_rst high at a clock edge):
  - o_rsp_valid=0, o_rsp_id=0, o_rsp_result=0.
  - Round-robin pointer rr_ptr=0.
  - While i_rst is high, o_req_ready is all-zero.
  - A reset mid-operation discards any pending response with no handshake.
- Slot-free condition: can_accept = !o_rsp_valid || i_rsp_ready. The response register behaves as a one-deep pipeline stage, so it can drain and refill in the same cycle.
- Arbitration (combinational):
  - Scan requesters starting at rr_ptr, ascending with wrap from NUM_REQ-1 to 0.
  - The first requester with i_req_valid=1 is the winner w.
  - o_req_ready has a single bit set, bit w, iff a winner exists and can_accept=1.
  - o_req_ready never depends on a losing requester's valid.
- ALU drive:
  - o_alu_op, o_alu_a and o_alu_b equal the winner's fields whenever a winner exists, regardless of can_accept.
  - With no winner they are driven to 0: opcode ADD, operands 0, so the ALU does not toggle.
- Accept (handshake fires) occurs when i_req_valid[w] && o_req_ready[w]. On that clock edge:
  - o_rsp_valid<=1, o_rsp_id<=w, o_rsp_result<=i_alu_result.
  - rr_ptr<=(w+1) mod NUM_REQ.
- Response:
  - Without an accept, if i_rsp_ready=1 then o_rsp_valid<=0.
  - Otherwise o_rsp_valid, o_rsp_id and o_rsp_result hold their values unchanged (stall).
- Latency and throughput:
  - A request accepted at edge N is visible on o_rsp_* after edge N.
  - With i_rsp_ready held high, one result per cycle.
- Fairness:
  - rr_ptr advances only on an accept.
  - With all requesters continuously valid, grants rotate 0,1,2,0,...
  - A requester waits at most NUM_REQ-1 grants.
- Requester contract: i_req_valid and its fields are held until ready is seen. The block does not check this.
- Opcodes are passed through unmodified. An undefined opcode returns whatever the ALU produces (0 from the team's ALU). No error flag.

Test Plan:
- Single op: after reset, req0 valid, op=4'b0000, a=5, b=7, i_rsp_ready=1.
  - Expect o_req_ready=3'b001 in the same cycle.
  - Next cycle: o_rsp_valid=1, o_rsp_id=0, o_rsp_result=12.
  - Following cycle: o_rsp_valid=0.
- Round-robin: all three requesters valid continuously, with ops SUB 10-3, XOR 0xF0^0x0F, and SLL 1<<4.
  - Over 6 cycles, o_rsp_id sequence is 0,1,2,0,1,2.
  - Results are 7, 0xFF, 0x10, repeating.
- Backpressure: req1 SRA a=0x80000000, b=4, with i_rsp_ready=0 for 3 cycles.
  - o_rsp_result holds at 0xF8000000, o_rsp_id holds at 1.
  - o_req_ready=0 while the stall lasts.
  - When i_rsp_ready rises, the pending req2 is accepted in that same cycle.
- Back-to-back refill: o_rsp_valid=1, i_rsp_ready=1 and req2 valid in the same cycle.
  - req2 is accepted that cycle with no bubble.
  - o_rsp_id becomes 2 on the next edge.
- Reset mid-operation: response pending with i_rsp_ready=0, assert i_rsp_ready-independent i_rst for 1 cycle.
  - o_rsp_valid=0 afterwards and rr_ptr=0.
  - With req1 and req2 valid, the next grant goes to req1.
- Undefined opcode: req0 op=4'b1111, a=3, b=3.
  - Expect o_rsp_result=0, o_rsp_id=0.
  - The request completes with a normal handshake.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
//
// Purpose:
//   Lets NUM_REQ requesters share one combinational 32-bit integer ALU.
//   - Grants rotate round-robin.
//   - The winner's opcode and operands drive the ALU.
//   - The ALU result is captured into a single-entry response register,
//     tagged with the ID of the requester that owns it.
//   - Throughput is one operation per cycle and latency is one cycle.
//   - Opcodes pass through unmodified. There is no error flag.
//
// Ports:
//   i_clk          clock; all state updates on the rising edge
//   i_rst          synchronous active-high reset
//   i_req_valid    per-requester request valid
//   o_req_ready    per-requester accept (combinational, at most one bit set)
//   i_req_op       packed 4-bit opcodes {funct7[5],funct3}, requester k at [4k+3:4k]
//   i_req_a        packed operand A, requester k at [32k+31:32k]
//   i_req_b        packed operand B, same packing as operand A
//   o_alu_op       opcode to the shared ALU (ADD when idle)
//   o_alu_a        operand A to the ALU (0 when idle)
//   o_alu_b        operand B to the ALU (0 when idle)
//   i_alu_result   combinational ALU result
//   o_rsp_valid    response register holds a result
//   o_rsp_id       index of the requester owning the response
//   o_rsp_result   registered ALU result
//   i_rsp_ready    consumer accepts the response
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int ID_W    = 2
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [NUM_REQ-1:0]      i_req_valid,
   output logic [NUM_REQ-1:0]      o_req_ready,
   input  logic [4*NUM_REQ-1:0]    i_req_op,
   input  logic [32*NUM_REQ-1:0]   i_req_a,
   input  logic [32*NUM_REQ-1:0]   i_req_b,
   output logic [3:0]              o_alu_op,
   output logic [31:0]             o_alu_a,
   output logic [31:0]             o_alu_b,
   input  logic [31:0]             i_alu_result,
   output logic                    o_rsp_valid,
   output logic [ID_W-1:0]         o_rsp_id,
   output logic [31:0]             o_rsp_result,
   input  logic                    i_rsp_ready
);

   logic [ID_W-1:0]      r_rr_ptr;
   logic                 r_rsp_valid;
   logic [ID_W-1:0]      r_rsp_id;
   logic [31:0]          r_rsp_result;

   logic [2*NUM_REQ-1:0] w_dbl;
   logic [NUM_REQ-1:0]   w_rot;
   logic                 w_found;
   logic [ID_W-1:0]      w_win;
   logic [ID_W:0]        w_sum;
   logic [ID_W-1:0]      w_win_next;
   logic [NUM_REQ-1:0]   w_grant;
   logic                 w_can_accept;
   logic                 w_accept;

   // Rotate the valid vector so that bit 0 corresponds to r_rr_ptr.
   // The first set bit is then the round-robin winner.
   assign w_dbl = {i_req_valid, i_req_valid};
   assign w_rot = NUM_REQ'(w_dbl >> r_rr_ptr);

   // Translate the rotated position back to a requester index.
   // The index is (rr_ptr + i) mod NUM_REQ.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_sum   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!w_found && w_rot[i]) begin
            w_found = 1'b1;
            w_sum   = {1'b0, r_rr_ptr} + (ID_W+1)'(i);
            if (w_sum >= (ID_W+1)'(NUM_REQ)) begin
               w_sum = w_sum - (ID_W+1)'(NUM_REQ);
            end
            w_win = w_sum[ID_W-1:0];
         end
      end
   end

   // Winner's fields drive the ALU whether or not the slot is free.
   // With no winner the ALU sees ADD 0,0 so it stays quiet.
   always_comb begin
      o_alu_op = '0;
      o_alu_a  = '0;
      o_alu_b  = '0;
      w_grant  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (w_found && (w_win == ID_W'(k))) begin
            o_alu_op   = i_req_op[4*k +: 4];
            o_alu_a    = i_req_a[32*k +: 32];
            o_alu_b    = i_req_b[32*k +: 32];
            w_grant[k] = 1'b1;
         end
      end
   end

   // The response register drains and refills in the same cycle.
   assign w_can_accept = !r_rsp_valid || i_rsp_ready;
   assign w_accept     = w_found && w_can_accept && !i_rst;
   assign o_req_ready  = w_accept ? w_grant : '0;

   assign w_win_next = (w_win == ID_W'(NUM_REQ-1)) ? '0 : w_win + 1'b1;

   // Response stage: capture ALU result at the accept edge.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rr_ptr     <= '0;
         r_rsp_valid  <= 1'b0;
         r_rsp_id     <= '0;
         r_rsp_result <= '0;
      end else if (w_accept) begin
         r_rr_ptr     <= w_win_next;
         r_rsp_valid  <= 1'b1;
         r_rsp_id     <= w_win;
         r_rsp_result <= i_alu_result;
      end else if (i_rsp_ready) begin
         r_rsp_valid  <= 1'b0;
      end
   end

   assign o_rsp_valid  = r_rsp_valid;
   assign o_rsp_id     = r_rsp_id;
   assign o_rsp_result = r_rsp_result;

endmodule
